// File: rtl/aska_npg_sched.sv
// aska_npg_sched: round-robin scheduler sharing one pulse output stage among
// NCH stimulation channels. It queues per-channel pulse requests, grants one
// channel at a time, issues a single-cycle start, waits for the stage, and then
// holds a guard interval so that pulses from different channels never overlap.
`timescale 1ns/1ps

module aska_npg_sched #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned GUARD_W = 4,
  parameter int unsigned TMO_W   = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    enable,
  input  logic [NCH-1:0]          chan_en,
  input  logic [NCH-1:0]          req,
  input  logic [GUARD_W-1:0]      guard_cycles,
  input  logic [TMO_W-1:0]        timeout_cycles,
  input  logic                    stage_busy,
  output logic                    start,
  output logic                    grant_valid,
  output logic [$clog2(NCH)-1:0]  grant_id,
  output logic [NCH-1:0]          pending,
  output logic [NCH-1:0]          overrun,
  output logic                    timeout_err,
  input  logic                    err_clr
);

  localparam int unsigned IDW = $clog2(NCH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_RUN,
    S_GUARD
  } state_t;

  state_t             state;
  state_t             state_n;

  logic [IDW-1:0]     last;
  logic [IDW-1:0]     sel_id;
  logic [IDW-1:0]     idx;
  logic               sel_found;

  logic               grant_fire;
  logic               tmo_hit;
  logic               tmo_set;
  logic               guard_done;

  logic [NCH-1:0]     grant_clr;
  logic [NCH-1:0]     req_set;
  logic [NCH-1:0]     pending_n;
  logic [NCH-1:0]     overrun_n;
  logic               timeout_err_n;

  logic [TMO_W-1:0]   wd_cnt;
  logic [TMO_W-1:0]   wd_cnt_n;
  logic [TMO_W-1:0]   wd_inc;
  logic [GUARD_W-1:0] guard_cnt;
  logic [GUARD_W-1:0] guard_cnt_n;
  logic [GUARD_W-1:0] guard_inc;

  // Round-robin pick: first pending channel after the last granted one.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    idx       = '0;
    for (int k = 1; k <= int'(NCH); k++) begin
      idx = IDW'((int'(last) + k) % int'(NCH));
      if (!sel_found && pending[idx]) begin
        sel_found = 1'b1;
        sel_id    = idx;
      end
    end
  end

  // Next-state, watchdog / guard counters and queue / error updates.
  always_comb begin
    state_n     = state;
    grant_fire  = 1'b0;
    tmo_set     = 1'b0;
    wd_cnt_n    = '0;
    guard_cnt_n = '0;
    wd_inc      = wd_cnt + TMO_W'(1);
    guard_inc   = guard_cnt + GUARD_W'(1);
    tmo_hit     = (timeout_cycles != '0) && (wd_inc == timeout_cycles);
    guard_done  = (guard_cycles == '0) || (guard_inc == guard_cycles);

    case (state)
      S_IDLE: begin
        if (sel_found) begin
          grant_fire = 1'b1;
          state_n    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_n = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        if (stage_busy) begin
          state_n = S_RUN;
        end else if (tmo_hit) begin
          tmo_set = 1'b1;
          state_n = S_GUARD;
        end else begin
          wd_cnt_n = wd_inc;
        end
      end
      S_RUN: begin
        if (!stage_busy) begin
          state_n = S_GUARD;
        end else if (tmo_hit) begin
          tmo_set = 1'b1;
          state_n = S_GUARD;
        end else begin
          wd_cnt_n = wd_inc;
        end
      end
      S_GUARD: begin
        if (guard_done) begin
          state_n = S_IDLE;
        end else begin
          guard_cnt_n = guard_inc;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Global disable aborts any activity; an abort is not a stage fault.
    if (!enable) begin
      state_n    = S_IDLE;
      grant_fire = 1'b0;
      tmo_set    = 1'b0;
    end

    grant_clr     = grant_fire ? (NCH'(1) << sel_id) : '0;
    req_set       = req & chan_en & {NCH{enable}};
    // A request arriving in the grant cycle re-queues the channel (set wins).
    pending_n     = (pending & ~grant_clr & chan_en & {NCH{enable}}) | req_set;
    overrun_n     = (err_clr ? '0 : overrun) | (req_set & pending & ~grant_clr);
    timeout_err_n = (err_clr ? 1'b0 : timeout_err) | tmo_set;
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Registered outputs, queue, pointer and counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start       <= 1'b0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      last        <= IDW'(NCH - 1);
      pending     <= '0;
      overrun     <= '0;
      timeout_err <= 1'b0;
      wd_cnt      <= '0;
      guard_cnt   <= '0;
    end else begin
      start       <= (state_n == S_ISSUE);
      grant_valid <= (state_n == S_ISSUE) || (state_n == S_WAIT_ACK) ||
                     (state_n == S_RUN);
      if (grant_fire) begin
        grant_id <= sel_id;
        last     <= sel_id;
      end
      pending     <= pending_n;
      overrun     <= overrun_n;
      timeout_err <= timeout_err_n;
      wd_cnt      <= wd_cnt_n;
      guard_cnt   <= guard_cnt_n;
    end
  end

endmodule

// File: tb/tb_aska_npg_sched.sv
// Bench for aska_npg_sched: a cycle trace table for the single-channel case,
// hand sequences for the multi-cycle corners, a simple pulse-stage model and a
// grant-order scoreboard popped on every start pulse.
`timescale 1ns/1ps

module tb_aska_npg_sched;

  localparam int unsigned NCH     = 4;
  localparam int unsigned GUARD_W = 4;
  localparam int unsigned TMO_W   = 8;
  localparam int unsigned IDW     = 2;
  localparam int          NVEC    = 15;

  logic               clk = 1'b0;
  logic               resetn;
  logic               enable;
  logic [NCH-1:0]     chan_en;
  logic [NCH-1:0]     req;
  logic [GUARD_W-1:0] guard_cycles;
  logic [TMO_W-1:0]   timeout_cycles;
  logic               stage_busy = 1'b0;
  logic               start;
  logic               grant_valid;
  logic [IDW-1:0]     grant_id;
  logic [NCH-1:0]     pending;
  logic [NCH-1:0]     overrun;
  logic               timeout_err;
  logic               err_clr;

  aska_npg_sched #(
    .NCH     (NCH),
    .GUARD_W (GUARD_W),
    .TMO_W   (TMO_W)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .enable         (enable),
    .chan_en        (chan_en),
    .req            (req),
    .guard_cycles   (guard_cycles),
    .timeout_cycles (timeout_cycles),
    .stage_busy     (stage_busy),
    .start          (start),
    .grant_valid    (grant_valid),
    .grant_id       (grant_id),
    .pending        (pending),
    .overrun        (overrun),
    .timeout_err    (timeout_err),
    .err_clr        (err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NCH-1:0] req;
    int             exp_grant;
    logic           start;
    logic           gv;
    logic [IDW-1:0] gid;
    logic [NCH-1:0] pend;
  } vec_t;

  vec_t tbl [NVEC];

  int   exp_q[$];
  int   start_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Pulse stage model: 0 = normal (busy for busy_len), 1 = never acks, 2 = stuck busy.
  int   stage_mode = 0;
  int   busy_len   = 6;
  int   busy_cnt   = 0;
  logic stage_kill = 1'b0;

  always @(posedge clk) begin
    #1;
    if (stage_kill) busy_cnt = 0;
    if (busy_cnt > 0) begin
      stage_busy = 1'b1;
      busy_cnt   = busy_cnt - 1;
    end else begin
      stage_busy = 1'b0;
    end
    if (start === 1'b1 && !stage_kill) begin
      if (stage_mode == 0) busy_cnt = busy_len;
      else if (stage_mode == 2) busy_cnt = 100000;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock; scoreboard pops whenever the DUT issues a start.
  task automatic next_cycle();
    @(posedge clk);
    #2;
    cyc++;
    if (start === 1'b1) begin
      start_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_start", int'(grant_id), -1);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("grant_order", int'(grant_id), e);
        check("grant_valid_with_start", int'(grant_valid), 1);
      end
    end
  endtask

  task automatic pulse_req(input logic [NCH-1:0] m);
    req = m;
    next_cycle();
    req = '0;
  endtask

  task automatic wait_start(input string name);
    int n = 0;
    while (start !== 1'b1 && n < 60) begin
      next_cycle();
      n++;
    end
    if (start !== 1'b1) check({name, "_start_timeout"}, 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((grant_valid === 1'b1 || pending !== '0 || exp_q.size() != 0) && n < 300) begin
      next_cycle();
      n++;
    end
    check("idle_reached", int'(n < 300), 1);
    repeat (4) next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    resetn         = 1'b0;
    enable         = 1'b1;
    chan_en        = '1;
    req            = '0;
    err_clr        = 1'b0;
    guard_cycles   = 4'd2;
    timeout_cycles = 8'd20;

    // Single channel trace: req[1] in cycle 0, stage busy cycles 3..8,
    // then req[0] during the guard interval proves IDLE is reached at 12.
    tbl[0]  = '{4'b0010,  1, 1'b0, 1'b0, 2'd0, 4'b0000};
    tbl[1]  = '{4'b0000, -1, 1'b0, 1'b0, 2'd0, 4'b0010};
    tbl[2]  = '{4'b0000, -1, 1'b1, 1'b1, 2'd1, 4'b0000};
    for (int i = 3; i <= 9; i++) tbl[i] = '{4'b0000, -1, 1'b0, 1'b1, 2'd1, 4'b0000};
    tbl[10] = '{4'b0001,  0, 1'b0, 1'b0, 2'd1, 4'b0000};
    tbl[11] = '{4'b0000, -1, 1'b0, 1'b0, 2'd1, 4'b0001};
    tbl[12] = '{4'b0000, -1, 1'b0, 1'b0, 2'd1, 4'b0001};
    tbl[13] = '{4'b0000, -1, 1'b1, 1'b1, 2'd0, 4'b0000};
    tbl[14] = '{4'b0000, -1, 1'b0, 1'b1, 2'd0, 4'b0000};

    repeat (3) next_cycle();
    check("rst_start", int'(start), 0);
    check("rst_grant_valid", int'(grant_valid), 0);
    check("rst_grant_id", int'(grant_id), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_timeout_err", int'(timeout_err), 0);
    resetn = 1'b1;
    repeat (3) next_cycle();

    // Table-driven single-channel sequence.
    for (int i = 0; i < NVEC; i++) begin
      check($sformatf("vec%0d_start", i), int'(start), int'(tbl[i].start));
      check($sformatf("vec%0d_grant_valid", i), int'(grant_valid), int'(tbl[i].gv));
      check($sformatf("vec%0d_grant_id", i), int'(grant_id), int'(tbl[i].gid));
      check($sformatf("vec%0d_pending", i), int'(pending), int'(tbl[i].pend));
      req = tbl[i].req;
      if (tbl[i].exp_grant >= 0) exp_q.push_back(tbl[i].exp_grant);
      next_cycle();
    end
    req = '0;
    wait_idle();

    // Request in the very cycle its channel is granted: re-queued, no overrun.
    req = 4'b0001; exp_q.push_back(0); next_cycle();
    req = 4'b0001; exp_q.push_back(0); next_cycle();
    req = '0;
    check("collide_start", int'(start), 1);
    check("collide_pending", int'(pending), 4'b0001);
    check("collide_overrun", int'(overrun), 0);
    wait_idle();

    // Asynchronous reset in the middle of a pulse.
    exp_q.push_back(2);
    pulse_req(4'b0100);
    wait_start("rst_mid");
    next_cycle();
    next_cycle();
    check("rst_mid_running", int'(grant_valid), 1);
    #1 resetn = 1'b0;
    #1;
    check("rst_mid_start", int'(start), 0);
    check("rst_mid_grant_valid", int'(grant_valid), 0);
    check("rst_mid_grant_id", int'(grant_id), 0);
    check("rst_mid_pending", int'(pending), 0);
    stage_kill = 1'b1;
    next_cycle();
    stage_kill = 1'b0;
    next_cycle();
    resetn = 1'b1;
    repeat (2) next_cycle();

    // Round-robin from reset pointer 3: 0 then 2; later 3 before 0.
    exp_q.push_back(0);
    exp_q.push_back(2);
    pulse_req(4'b0101);
    check("rr_pending", int'(pending), 4'b0101);
    wait_idle();
    exp_q.push_back(3);
    exp_q.push_back(0);
    pulse_req(4'b1001);
    wait_idle();

    // Overrun: channel 2 requests twice while channel 1 runs.
    exp_q.push_back(1);
    pulse_req(4'b0010);
    wait_start("ovr");
    req = 4'b0100; exp_q.push_back(2); next_cycle();
    req = 4'b0100; next_cycle();
    req = '0;
    check("ovr_overrun", int'(overrun), 4'b0100);
    check("ovr_pending", int'(pending), 4'b0100);
    next_cycle();
    check("ovr_sticky", int'(overrun), 4'b0100);
    err_clr = 1'b1; next_cycle(); err_clr = 1'b0;
    check("ovr_cleared", int'(overrun), 0);
    check("ovr_pending_kept", int'(pending), 4'b0100);
    wait_idle();

    // Watchdog: stage never acknowledges.
    timeout_cycles = 8'd5;
    stage_mode     = 1;
    exp_q.push_back(3);
    pulse_req(4'b1000);
    wait_start("wd_noack");
    repeat (5) next_cycle();
    check("wd_noack_still_waiting", int'(grant_valid), 1);
    check("wd_noack_no_err_yet", int'(timeout_err), 0);
    next_cycle();
    check("wd_noack_err", int'(timeout_err), 1);
    check("wd_noack_released", int'(grant_valid), 0);
    err_clr = 1'b1; next_cycle(); err_clr = 1'b0;
    check("wd_err_cleared", int'(timeout_err), 0);
    wait_idle();

    // Watchdog: stage stuck busy in RUN.
    stage_mode = 2;
    exp_q.push_back(0);
    pulse_req(4'b0001);
    wait_start("wd_stuck");
    repeat (6) next_cycle();
    check("wd_stuck_still_running", int'(grant_valid), 1);
    check("wd_stuck_no_err_yet", int'(timeout_err), 0);
    next_cycle();
    check("wd_stuck_err", int'(timeout_err), 1);
    check("wd_stuck_released", int'(grant_valid), 0);
    stage_kill = 1'b1; next_cycle(); stage_kill = 1'b0;
    stage_mode = 0;
    wait_idle();
    check("wd_err_sticky", int'(timeout_err), 1);
    err_clr = 1'b1; next_cycle(); err_clr = 1'b0;
    timeout_cycles = 8'd0;

    // Zero guard, all channels pending from reset: 0,1,2,3 back-to-back.
    resetn = 1'b0; next_cycle(); resetn = 1'b1;
    repeat (2) next_cycle();
    guard_cycles = 4'd0;
    busy_len     = 2;
    begin
      int base;
      base = start_cyc.size();
      for (int c = 0; c < 4; c++) exp_q.push_back(c);
      pulse_req(4'b1111);
      wait_idle();
      check("g0_grant_count", start_cyc.size() - base, 4);
      if (start_cyc.size() - base == 4) begin
        for (int k = 1; k < 4; k++)
          check($sformatf("g0_spacing%0d", k), start_cyc[base+k] - start_cyc[base+k-1], 6);
      end
    end

    // Drop enable while running with two channels queued.
    guard_cycles = 4'd2;
    busy_len     = 10;
    exp_q.push_back(0);
    pulse_req(4'b0001);
    wait_start("en");
    req = 4'b0110; next_cycle(); req = '0;
    check("en_queued", int'(pending), 4'b0110);
    next_cycle();
    next_cycle();
    check("en_running", int'(grant_valid), 1);
    enable = 1'b0;
    next_cycle();
    check("en_off_grant_valid", int'(grant_valid), 0);
    check("en_off_start", int'(start), 0);
    check("en_off_pending", int'(pending), 0);
    req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      req = '0;
      check($sformatf("en_off_idle%0d", k), int'(start) + int'(pending), 0);
    end
    stage_kill = 1'b1; next_cycle(); stage_kill = 1'b0;
    enable = 1'b1;
    exp_q.push_back(3);
    pulse_req(4'b1000);
    wait_idle();

    // Disabled channel requests are ignored.
    chan_en = 4'b1110;
    pulse_req(4'b0001);
    check("chan_off_pending", int'(pending), 0);
    next_cycle();
    check("chan_off_no_start", int'(start), 0);
    chan_en = '1;
    repeat (3) next_cycle();

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
